// File: rtl/div_iter_if.sv
// Handshake and data bundle between the EX-stage issue logic and the
// iterative divider. The master issues operations and acknowledges results.
// The slave is the divider.
interface div_iter_if #(
  parameter int WIDTH = 32
) ();
  logic               start;
  logic               sign;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               cancel;
  logic               ack;
  logic               busy;
  logic               valid;
  logic [2*WIDTH-1:0] divres;

  modport master (
    output start, sign, opa, opb, cancel, ack,
    input  busy, valid, divres
  );

  modport slave (
    input  start, sign, opa, opb, cancel, ack,
    output busy, valid, divres
  );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// The result is packed as {remainder, quotient}, which is the hi/lo order
// that the MEM-stage HILO logic uses.
//
// state | meaning
// IDLE  | waiting for start; operands are sampled here
// CALC  | one quotient bit per cycle, MSB first, on the operand magnitudes
// FIX   | applies the quotient and remainder signs and registers divres
// DONE  | result valid and held until ack
module div_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       resetn,
  div_iter_if.slave bus
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   prem;
  logic               qneg;
  logic               rneg;
  logic               valid_q;
  logic [2*WIDTH-1:0] divres_q;
  logic               busy_c;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             take;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes. Unsigned operations use the raw operand bits.
  assign mag_a = (bus.sign && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
  assign mag_b = (bus.sign && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

  // Restoring step. The remainder always stays below the divisor, so the
  // low WIDTH bits of the trial difference are exact whenever it is taken.
  assign shifted = {prem, quo[WIDTH-1]};
  assign trial   = shifted[WIDTH-1:0] - dvsr;
  assign take    = (shifted >= {1'b0, dvsr});

  assign quot_fix = qneg ? -quo  : quo;
  assign rem_fix  = rneg ? -prem : prem;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and the combinational stall request. cancel overrides everything.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_c  = 1'b1;
          state_d = (mag_b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy_c = 1'b1;
        if (cnt == LAST) state_d = FIX;
      end
      FIX: begin
        busy_c  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.cancel) begin
      state_d = IDLE;
      busy_c  = 1'b0;
    end
  end

  // Datapath: operand capture, iteration, sign fix-up and result hold.
  // divres is loaded only when entering DONE, so it is stable while valid is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      dvsr     <= '0;
      quo      <= '0;
      prem     <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      valid_q  <= 1'b0;
      divres_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            dvsr <= mag_b;
            quo  <= mag_a;
            prem <= '0;
            cnt  <= '0;
            qneg <= bus.sign & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            rneg <= bus.sign & bus.opa[WIDTH-1];
            if (mag_b == '0) divres_q <= {bus.opa, {WIDTH{1'b1}}};
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            prem <= take ? trial : shifted[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], take};
            if (cnt != LAST) cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!bus.cancel) divres_q <= {rem_fix, quot_fix};
        end
        default: ;
      endcase
      valid_q <= (state_d == DONE);
    end
  end

  assign bus.busy   = busy_c;
  assign bus.valid  = valid_q;
  assign bus.divres = divres_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter. It runs fixed directed vectors, handwritten
// cancel, hold and reset sequences, and random operations checked against an
// arithmetic reference model.
module tb_div_iter;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic (truncating division).
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one operation and wait for valid.
  // lat is the cycle in which valid is first seen, or -1 if valid never arrives.
  // busy_ok is set when busy is high in every cycle before lat and low at lat.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output bit busy_ok);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.sign  = s;
    bus.opa   = a;
    bus.opb   = b;
    lat       = -1;
    busy_ok   = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.valid) begin
        lat = c;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.sign  = ~s;
      bus.opa   = $urandom;
      bus.opb   = $urandom;
    end
    res = bus.divres;
  endtask

  // Acknowledge from the negedge of a valid cycle. valid must drop in the next cycle.
  task automatic do_ack(input string name);
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    @(negedge clk);
    chk(name, {65'd0, bus.valid}, 66'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0000_0000;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(1, 15));
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  vec_t        vecs[10];
  logic [63:0] res;
  logic [63:0] held;
  int          lat;
  bit          bok;

  initial begin
    checks     = 0;
    errors     = 0;
    bus.start  = 1'b0;
    bus.sign   = 1'b0;
    bus.opa    = '0;
    bus.opb    = '0;
    bus.cancel = 1'b0;
    bus.ack    = 1'b0;
    resetn     = 1'b0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2,         32'd14}};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,         32'hFFFF_FFFD}};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,         32'h8000_0000}};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,         32'hFFFF_FFFF}};
    vecs[5] = '{1'b0, 32'd5,          32'd0,          {32'd5,         32'hFFFF_FFFF}};
    vecs[6] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
    vecs[7] = '{1'b0, 32'd7,          32'd9,          {32'd7,         32'd0}};
    vecs[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14}};
    vecs[9] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0}};

    #12;
    chk("reset_outputs", {bus.busy, bus.valid, bus.divres}, 66'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sign, vecs[i].a, vecs[i].b, res, lat, bok);
      chk($sformatf("vec%0d_divres", i), {2'b0, res}, {2'b0, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), 66'(lat), (vecs[i].b == 32'd0) ? 66'd1 : 66'd34);
      chk($sformatf("vec%0d_busy", i), {65'd0, bok}, 66'd1);
      do_ack($sformatf("vec%0d_ack", i));
    end

    // A cancel in cycle 10 of 50/3 drops busy in that cycle and valid never appears.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sign = 1'b0; bus.opa = 32'd50; bus.opb = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    bus.cancel = 1'b1;
    @(negedge clk);
    chk("cancel_busy", {65'd0, bus.busy}, 66'd0);
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) lat++;
    end
    chk("cancel_quiet", 66'(lat), 66'd0);
    run_op(1'b0, 32'd20, 32'd3, res, lat, bok);
    chk("after_cancel_divres", {2'b0, res}, {2'b0, 32'd2, 32'd6});
    chk("after_cancel_latency", 66'(lat), 66'd34);

    // While ack is held low in DONE, valid and divres stay stable and start is ignored.
    held = res;
    bus.start = 1'b1; bus.opa = 32'd9; bus.opb = 32'd4;
    lat = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!bus.valid || bus.busy || bus.divres !== held) lat++;
    end
    bus.start = 1'b0;
    chk("hold_stable", 66'(lat), 66'd0);
    do_ack("hold_ack");

    // A cancel that coincides with ack in DONE clears valid and keeps divres.
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, bok);
    bus.ack = 1'b1; bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    chk("cancel_ack", {bus.busy, bus.valid, bus.divres}, {2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Asserting reset mid-CALC clears the outputs immediately, without waiting for a clock edge.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sign = 1'b0; bus.opa = 32'd100; bus.opb = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("reset_mid_calc", {bus.busy, bus.valid, bus.divres}, 66'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(1'b0, 32'd100, 32'd7, res, lat, bok);
    chk("after_reset_divres", {2'b0, res}, {2'b0, 32'd2, 32'd14});
    do_ack("after_reset_ack");

    // Random operations checked against the arithmetic model.
    for (int i = 0; i < 120; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      run_op(s, a, b, res, lat, bok);
      chk($sformatf("rnd%0d_divres s=%0d a=%h b=%h", i, s, a, b), {2'b0, res}, {2'b0, ref_div(s, a, b)});
      chk($sformatf("rnd%0d_latency", i), 66'(lat), (b == 32'd0) ? 66'd1 : 66'd34);
      chk($sformatf("rnd%0d_busy", i), {65'd0, bok}, 66'd1);
      do_ack($sformatf("rnd%0d_ack", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
